// File: rtl/fpnew_divsqrt_arbiter_pkg.sv
// Shared FPU types for the divsqrt arbiter slice: operation, rounding, format and status encodings.
package fpnew_divsqrt_arbiter_pkg;

    typedef enum logic [3:0] {
        FMADD  = 4'd0,
        FNMSUB = 4'd1,
        ADD    = 4'd2,
        MUL    = 4'd3,
        DIV    = 4'd4,
        SQRT   = 4'd5
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpnew_divsqrt_id_fifo.sv
// Ordered queue of requester IDs for operations in flight inside the divsqrt unit.
module fpnew_divsqrt_id_fifo
    import fpnew_divsqrt_arbiter_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataWidth = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrWidth = id_width(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 do_push, do_pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Flush discards every entry; storage contents become don't-care.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CntWidth'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fpnew_divsqrt_arbiter.sv
// Round-robin sharing of one divsqrt unit between NumReq requesters, with in-order
// routing of results back to the issuing requester.
module fpnew_divsqrt_arbiter
    import fpnew_divsqrt_arbiter_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned Width       = 64,
    parameter int unsigned TagWidth    = 4,
    parameter int unsigned MaxInflight = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq-1:0]                    req_valid_i,
    output logic [NumReq-1:0]                    req_ready_o,
    input  logic [NumReq-1:0][1:0][Width-1:0]    req_operands_i,
    input  operation_e [NumReq-1:0]              req_op_i,
    input  roundmode_e [NumReq-1:0]              req_rnd_mode_i,
    input  fp_format_e [NumReq-1:0]              req_dst_fmt_i,
    input  logic [NumReq-1:0][TagWidth-1:0]      req_tag_i,
    output logic                                 unit_valid_o,
    input  logic                                 unit_ready_i,
    output logic [1:0][Width-1:0]                unit_operands_o,
    output operation_e                           unit_op_o,
    output roundmode_e                           unit_rnd_mode_o,
    output fp_format_e                           unit_dst_fmt_o,
    output logic [TagWidth-1:0]                  unit_tag_o,
    input  logic                                 unit_out_valid_i,
    output logic                                 unit_out_ready_o,
    input  logic [Width-1:0]                     unit_result_i,
    input  status_t                              unit_status_i,
    input  logic [TagWidth-1:0]                  unit_tag_i,
    output logic [NumReq-1:0]                    resp_valid_o,
    input  logic [NumReq-1:0]                    resp_ready_i,
    output logic [Width-1:0]                     resp_result_o,
    output status_t                              resp_status_o,
    output logic [TagWidth-1:0]                  resp_tag_o,
    input  logic                                 flush_i,
    output logic                                 busy_o,
    output logic                                 orphan_o
);

    localparam int unsigned IdWidth = id_width(NumReq);
    typedef logic [IdWidth-1:0] id_t;

    typedef struct packed {
        logic [1:0][Width-1:0] operands;
        operation_e            op;
        roundmode_e            rnd_mode;
        fp_format_e            dst_fmt;
        logic [TagWidth-1:0]   tag;
    } divsqrt_req_t;

    id_t          rr_q, gnt_q, arb_idx, gnt_idx, head_id;
    logic         lock_q, any_valid, full, empty, issue_fire, pop;
    logic [IdWidth:0] cand;
    logic         found;
    divsqrt_req_t [NumReq-1:0] reqs;
    divsqrt_req_t gnt_req;

    // Search starts one past the last accepted winner so every requester gets a turn.
    always_comb begin
        arb_idx = rr_q;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            cand = {1'b0, rr_q} + (IdWidth + 1)'(i);
            if (cand >= (IdWidth + 1)'(NumReq)) cand = cand - (IdWidth + 1)'(NumReq);
            if (!found && req_valid_i[id_t'(cand)]) begin
                arb_idx = id_t'(cand);
                found   = 1'b1;
            end
        end
    end

    assign any_valid    = |req_valid_i;
    assign gnt_idx      = lock_q ? gnt_q : arb_idx;
    assign unit_valid_o = any_valid & ~full & ~flush_i;
    assign issue_fire   = unit_valid_o & unit_ready_i;

    always_comb begin
        reqs = '0;
        for (int r = 0; r < NumReq; r++) begin
            reqs[r].operands = req_operands_i[r];
            reqs[r].op       = req_op_i[r];
            reqs[r].rnd_mode = req_rnd_mode_i[r];
            reqs[r].dst_fmt  = req_dst_fmt_i[r];
            reqs[r].tag      = req_tag_i[r];
        end
        gnt_req = reqs[gnt_idx];
    end

    assign unit_operands_o = gnt_req.operands;
    assign unit_op_o       = gnt_req.op;
    assign unit_rnd_mode_o = gnt_req.rnd_mode;
    assign unit_dst_fmt_o  = gnt_req.dst_fmt;
    assign unit_tag_o      = gnt_req.tag;

    // An empty queue or a flush drains the unit output so stray results never stall it.
    always_comb begin
        req_ready_o = '0;
        if (any_valid && unit_ready_i && !full && !flush_i) req_ready_o[gnt_idx] = 1'b1;
        resp_valid_o = '0;
        if (unit_out_valid_i && !empty && !flush_i) resp_valid_o[head_id] = 1'b1;
        unit_out_ready_o = (empty || flush_i) ? 1'b1 : resp_ready_i[head_id];
    end

    assign pop           = unit_out_valid_i & unit_out_ready_o & ~empty;
    assign resp_result_o = unit_result_i;
    assign resp_status_o = unit_status_i;
    assign resp_tag_o    = unit_tag_i;
    assign busy_o        = ~empty | any_valid;

    fpnew_divsqrt_id_fifo #(
        .Depth     (MaxInflight),
        .DataWidth (IdWidth)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (issue_fire),
        .data_i  (gnt_idx),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (full),
        .empty_o (empty)
    );

    // The grant is frozen while an offer waits on backpressure so the payload stays stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= id_t'(NumReq - 1);
            gnt_q    <= '0;
            lock_q   <= 1'b0;
            orphan_o <= 1'b0;
        end else begin
            orphan_o <= unit_out_valid_i & empty;
            if (flush_i) begin
                lock_q <= 1'b0;
            end else if (issue_fire) begin
                lock_q <= 1'b0;
                rr_q   <= gnt_idx;
            end else if (unit_valid_o) begin
                lock_q <= 1'b1;
                gnt_q  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// Directed bench for fpnew_divsqrt_arbiter with a queue-based reference model checked every cycle.
module tb_fpnew_divsqrt_arbiter;
    import fpnew_divsqrt_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int W  = 64;
    localparam int TW = 4;
    localparam int MI = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]               req_valid, req_ready;
    logic [NR-1:0][1:0][W-1:0]   req_operands;
    operation_e [NR-1:0]         req_op;
    roundmode_e [NR-1:0]         req_rnd;
    fp_format_e [NR-1:0]         req_fmt;
    logic [NR-1:0][TW-1:0]       req_tag;
    logic                        unit_valid, unit_ready;
    logic [1:0][W-1:0]           unit_operands;
    operation_e                  unit_op;
    roundmode_e                  unit_rnd;
    fp_format_e                  unit_fmt;
    logic [TW-1:0]               unit_tag;
    logic                        unit_out_valid, unit_out_ready;
    logic [W-1:0]                unit_result;
    status_t                     unit_status;
    logic [TW-1:0]               unit_tag_in;
    logic [NR-1:0]               resp_valid, resp_ready;
    logic [W-1:0]                resp_result;
    status_t                     resp_status;
    logic [TW-1:0]               resp_tag;
    logic                        flush, busy, orphan;

    logic          emu_en = 1'b0;
    logic          emu_out_valid = 1'b0;
    logic [W-1:0]  emu_result = '0;
    logic [TW-1:0] emu_tag = '0;
    logic          d_out_valid;
    logic [W-1:0]  d_result;
    logic [TW-1:0] d_tag;

    assign unit_out_valid = emu_en ? emu_out_valid : d_out_valid;
    assign unit_result    = emu_en ? emu_result : d_result;
    assign unit_tag_in    = emu_en ? emu_tag : d_tag;
    assign unit_status    = emu_en ? 5'b00001 : 5'b10000;

    fpnew_divsqrt_arbiter #(
        .NumReq(NR), .Width(W), .TagWidth(TW), .MaxInflight(MI)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operands_i(req_operands), .req_op_i(req_op),
        .req_rnd_mode_i(req_rnd), .req_dst_fmt_i(req_fmt), .req_tag_i(req_tag),
        .unit_valid_o(unit_valid), .unit_ready_i(unit_ready),
        .unit_operands_o(unit_operands), .unit_op_o(unit_op),
        .unit_rnd_mode_o(unit_rnd), .unit_dst_fmt_o(unit_fmt), .unit_tag_o(unit_tag),
        .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready),
        .unit_result_i(unit_result), .unit_status_i(unit_status), .unit_tag_i(unit_tag_in),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_result_o(resp_result), .resp_status_o(resp_status), .resp_tag_o(resp_tag),
        .flush_i(flush), .busy_o(busy), .orphan_o(orphan)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [NR-1:0] valid, input logic ready);
        req_valid  = valid;
        unit_ready = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: ordered owner queue, last winner, and a pending (unaccepted) offer.
    int   m_rr = NR - 1;
    bit   m_held = 0;
    int   m_held_idx = 0;
    int   m_q[$];
    bit   m_orphan = 0;
    int   fire_log[$];
    int   resp_owner_log[$];
    logic [TW-1:0] resp_tag_log[$];

    always @(negedge clk) begin
        int win, head, idx;
        bit full_m, empty_m, anyv, e_uvalid, e_oready, fire, pop_m, found;
        logic [NR-1:0] e_rready, e_rvalid;
        if (!rst_n) begin
            m_rr = NR - 1;
            m_held = 0;
            m_q.delete();
            m_orphan = 0;
        end else begin
            full_m  = (m_q.size() == MI);
            empty_m = (m_q.size() == 0);
            anyv    = |req_valid;
            win     = 0;
            found   = 0;
            if (m_held) win = m_held_idx;
            else for (int k = 1; k <= NR; k++) begin
                idx = (m_rr + k) % NR;
                if (!found && req_valid[idx]) begin win = idx; found = 1; end
            end
            e_uvalid = anyv && !full_m && !flush;
            e_rready = (e_uvalid && unit_ready) ? NR'(1 << win) : '0;
            head     = empty_m ? 0 : m_q[0];
            e_rvalid = (unit_out_valid && !empty_m && !flush) ? NR'(1 << head) : '0;
            e_oready = (empty_m || flush) ? 1'b1 : resp_ready[head];

            check_output("m_unit_valid", W'(unit_valid), W'(e_uvalid));
            check_output("m_req_ready", W'(req_ready), W'(e_rready));
            check_output("m_resp_valid", W'(resp_valid), W'(e_rvalid));
            check_output("m_out_ready", W'(unit_out_ready), W'(e_oready));
            check_output("m_busy", W'(busy), W'(!empty_m || anyv));
            check_output("m_orphan", W'(orphan), W'(m_orphan));
            if (e_uvalid) begin
                check_output("m_unit_tag", W'(unit_tag), W'(req_tag[win]));
                check_output("m_unit_opa", unit_operands[0], req_operands[win][0]);
                check_output("m_unit_opb", unit_operands[1], req_operands[win][1]);
                check_output("m_unit_op", W'(unit_op), W'(req_op[win]));
            end
            if (e_rvalid != '0) begin
                check_output("m_resp_tag", W'(resp_tag), W'(unit_tag_in));
                check_output("m_resp_res", resp_result, unit_result);
                check_output("m_resp_st", W'(resp_status), W'(unit_status));
            end

            fire  = e_uvalid && unit_ready;
            pop_m = unit_out_valid && e_oready && !empty_m;
            if (pop_m && !flush) begin
                resp_owner_log.push_back(head);
                resp_tag_log.push_back(resp_tag);
            end
            m_orphan = unit_out_valid && empty_m;
            if (flush) begin
                m_q.delete();
                m_held = 0;
            end else begin
                if (pop_m) void'(m_q.pop_front());
                if (fire) begin
                    m_q.push_back(win);
                    m_rr = win;
                    m_held = 0;
                    fire_log.push_back(win);
                end else if (e_uvalid) begin
                    m_held = 1;
                    m_held_idx = win;
                end
            end
        end
    end

    // Unit emulator: in-order, fixed three-cycle latency, holds results under backpressure.
    typedef struct { int due; logic [TW-1:0] tag; logic [W-1:0] res; } pend_t;
    pend_t pend[$];
    int emu_cyc = 0;

    always @(negedge clk) begin
        if (emu_en) begin
            emu_cyc++;
            if (emu_out_valid && unit_out_ready && pend.size() > 0) void'(pend.pop_front());
            if (unit_valid && unit_ready)
                pend.push_back('{due: emu_cyc + 3, tag: unit_tag, res: unit_operands[0] ^ 64'hFFFF});
        end
    end

    always @(posedge clk) begin
        #1;
        if (emu_en && pend.size() > 0 && pend[0].due <= emu_cyc + 1) begin
            emu_out_valid = 1'b1;
            emu_tag       = pend[0].tag;
            emu_result    = pend[0].res;
        end else begin
            emu_out_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int exp_own[4];
        logic [TW-1:0] exp_tag[4];
        exp_own = '{0, 1, 0, 1};
        exp_tag = '{4'hA, 4'h5, 4'hA, 4'h5};

        for (int r = 0; r < NR; r++) begin
            req_operands[r][0] = 64'h1000 + 64'(r);
            req_operands[r][1] = 64'h2000 + 64'(r);
        end
        req_op  = {SQRT, DIV};
        req_rnd = {RTZ, RNE};
        req_fmt = {FP32, FP64};
        req_tag = {4'h5, 4'hA};
        apply_stimulus(2'b00, 1'b0);
        resp_ready = 2'b11;
        flush = 1'b0;
        d_out_valid = 1'b0;
        d_result = 64'hBEEF;
        d_tag = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        $display("[TB] reset and idle");
        check_output("rst_req_ready", W'(req_ready), 0);
        check_output("rst_resp_valid", W'(resp_valid), 0);
        check_output("rst_out_ready", W'(unit_out_ready), 1);
        check_output("rst_busy", W'(busy), 0);
        check_output("rst_orphan", W'(orphan), 0);

        step();
        apply_stimulus(2'b11, 1'b1);
        #1 check_output("first_grant", W'(req_ready), 2'b01);
        check_output("first_tag", W'(unit_tag), 4'hA);
        step();
        check_output("second_grant", W'(req_ready), 2'b10);
        step();
        apply_stimulus(2'b00, 1'b1);
        d_out_valid = 1'b1;
        d_tag = 4'hA;
        #1 check_output("route_r0", W'(resp_valid), 2'b01);
        step();
        d_tag = 4'h5;
        #1 check_output("route_r1", W'(resp_valid), 2'b10);
        step();
        d_out_valid = 1'b0;

        $display("[TB] streaming with three-cycle unit");
        fire_log.delete();
        resp_owner_log.delete();
        resp_tag_log.delete();
        emu_en = 1'b1;
        apply_stimulus(2'b11, 1'b1);
        repeat (16) step();
        apply_stimulus(2'b00, 1'b1);
        for (int n = 0; n < 60 && (busy || pend.size() > 0); n++) step();
        check_output("stream_drain", W'(busy), 0);
        emu_en = 1'b0;
        check_output("stream_fires", W'(fire_log.size() >= 4), 1);
        check_output("stream_resps", W'(resp_owner_log.size() >= 4), 1);
        for (int i = 0; i < 4 && i < fire_log.size(); i++)
            check_output("stream_grant_seq", W'(fire_log[i]), W'(exp_own[i]));
        for (int i = 0; i < 4 && i < resp_owner_log.size(); i++) begin
            check_output("stream_resp_owner", W'(resp_owner_log[i]), W'(exp_own[i]));
            check_output("stream_resp_tag", W'(resp_tag_log[i]), W'(exp_tag[i]));
        end

        $display("[TB] backpressure with grant lock");
        apply_stimulus(2'b10, 1'b0);
        #1 check_output("stall_valid", W'(unit_valid), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 1) req_valid = 2'b11;
            #1 check_output("stall_tag", W'(unit_tag), 4'h5);
            check_output("stall_opa", unit_operands[0], 64'h1001);
            check_output("stall_ready", W'(req_ready), 0);
        end
        step();
        unit_ready = 1'b1;
        #1 check_output("stall_release", W'(req_ready), 2'b10);
        step();
        check_output("stall_next_r0", W'(req_ready), 2'b01);
        check_output("stall_next_tag", W'(unit_tag), 4'hA);
        step();

        $display("[TB] queue full");
        apply_stimulus(2'b01, 1'b1);
        #1 check_output("full_ready", W'(req_ready), 0);
        check_output("full_valid", W'(unit_valid), 0);
        step();
        d_out_valid = 1'b1;
        d_tag = 4'h5;
        #1 check_output("full_pop_ready", W'(req_ready), 0);
        check_output("full_pop_route", W'(resp_valid), 2'b10);
        step();
        d_out_valid = 1'b0;
        #1 check_output("full_after", W'(req_ready), 2'b01);
        step();
        apply_stimulus(2'b00, 1'b1);

        $display("[TB] response backpressure");
        d_out_valid = 1'b1;
        d_tag = 4'hA;
        resp_ready = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1 check_output("rbp_out_ready", W'(unit_out_ready), 0);
            check_output("rbp_resp_valid", W'(resp_valid), 2'b01);
            step();
        end
        resp_ready = 2'b11;
        #1 check_output("rbp_release", W'(unit_out_ready), 1);
        step();
        d_out_valid = 1'b0;

        $display("[TB] flush then orphan");
        apply_stimulus(2'b10, 1'b1);
        step();
        apply_stimulus(2'b01, 1'b1);
        flush = 1'b1;
        d_out_valid = 1'b1;
        #1 check_output("flush_req_ready", W'(req_ready), 0);
        check_output("flush_resp_valid", W'(resp_valid), 0);
        step();
        flush = 1'b0;
        d_out_valid = 1'b0;
        apply_stimulus(2'b00, 1'b1);
        #1 check_output("flush_empty", W'(busy), 0);
        d_out_valid = 1'b1;
        d_tag = 4'h5;
        #1 check_output("orphan_resp", W'(resp_valid), 0);
        check_output("orphan_drain", W'(unit_out_ready), 1);
        step();
        d_out_valid = 1'b0;
        #1 check_output("orphan_pulse", W'(orphan), 1);
        step();
        check_output("orphan_clear", W'(orphan), 0);

        $display("[TB] reset mid-operation");
        apply_stimulus(2'b01, 1'b1);
        step();
        apply_stimulus(2'b00, 1'b1);
        rst_n = 1'b0;
        #1 check_output("midrst_busy", W'(busy), 0);
        check_output("midrst_out_ready", W'(unit_out_ready), 1);
        step();
        rst_n = 1'b1;
        d_out_valid = 1'b1;
        #1 check_output("midrst_resp", W'(resp_valid), 0);
        step();
        d_out_valid = 1'b0;
        #1 check_output("midrst_orphan", W'(orphan), 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
